// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals between requesters, the shared ALU
// and alu_arbiter.
interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*5-1:0]  req_op;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*12-1:0] req_imm;

  logic [4:0]            alu_op_code;
  logic [31:0]           alu_operand_a;
  logic [31:0]           alu_operand_b;
  logic [11:0]           alu_immediate;
  logic [31:0]           alu_result;
  logic                  alu_zero;

  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_zero;
  logic                  rsp_illegal;
  logic                  busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_imm, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_op_code, alu_operand_a, alu_operand_b, alu_immediate,
    output rsp_valid, rsp_result, rsp_zero, rsp_illegal, busy
  );

  // Requester / ALU side.
  modport master (
    output req_valid, req_op, req_a, req_b, req_imm, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_op_code, alu_operand_a, alu_operand_b, alu_immediate,
    input  rsp_valid, rsp_result, rsp_zero, rsp_illegal, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ALU among NUM_REQ requesters;
// each grant runs IDLE -> EXEC -> RESP with a registered result handed back.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned OP_MAX  = 18
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  idx_t        ptr_q, ptr_d;
  idx_t        owner_q, owner_d;
  idx_t        winner;
  logic        found;
  logic        accept;
  logic        rsp_done;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [11:0] imm_q, imm_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        illegal_q, illegal_d;

  function automatic idx_t wrap(input int unsigned v);
    return idx_t'(v % NUM_REQ);
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[wrap(32'(ptr_q) + k)]) begin
        found  = 1'b1;
        winner = wrap(32'(ptr_q) + k);
      end
    end
  end

  assign accept   = (state_q == StIdle) && found && !rst;
  assign rsp_done = (state_q == StResp) && bus.rsp_ready[owner_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
          ptr_d   = wrap(32'(winner) + 32'd1);
          owner_d = winner;
          op_d    = bus.req_op[32'(winner) * 5 +: 5];
          a_d     = bus.req_a[32'(winner) * 32 +: 32];
          b_d     = bus.req_b[32'(winner) * 32 +: 32];
          imm_d   = bus.req_imm[32'(winner) * 12 +: 12];
        end
      end
      StExec: begin
        state_d   = StResp;
        illegal_d = 32'(op_q) > OP_MAX;
        // Illegal ops report a forced zero regardless of what the ALU produced.
        result_d  = illegal_d ? 32'd0 : bus.alu_result;
        zero_d    = illegal_d | bus.alu_zero;
      end
      StResp: begin
        if (rsp_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (accept) bus.req_ready[winner] = 1'b1;
    if (state_q == StResp) bus.rsp_valid[owner_q] = 1'b1;
  end

  assign bus.alu_op_code   = op_q;
  assign bus.alu_operand_a = a_q;
  assign bus.alu_operand_b = b_q;
  assign bus.alu_immediate = imm_q;
  assign bus.rsp_result    = result_q;
  assign bus.rsp_zero      = zero_q;
  assign bus.rsp_illegal   = illegal_q;
  assign bus.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a round-robin / result reference model,
// driven with directed and $urandom transactions.
module tb_alu_arbiter;
  localparam int N     = 3;
  localparam int OPMAX = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(N)) bus ();
  alu_arbiter #(.NUM_REQ(N), .OP_MAX(OPMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [4:0]  r_op[N];
  logic [31:0] r_a[N];
  logic [31:0] r_b[N];
  logic [11:0] r_imm[N];
  int ref_ptr;
  int n_checks = 0;
  int n_pass = 0;

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [11:0] imm);
    logic [31:0] i;
    i = {{20{imm[11]}}, imm};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return {31'd0, $signed(a) < $signed(b)};
      5'd4:  return {31'd0, a < b};
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return $signed(a) >>> b[4:0];
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return a + i;
      5'd11: return {31'd0, $signed(a) < $signed(i)};
      5'd12: return {31'd0, a < i};
      5'd13: return a ^ i;
      5'd14: return a << imm[4:0];
      5'd15: return a >> imm[4:0];
      5'd16: return $signed(a) >>> imm[4:0];
      5'd17: return a | i;
      5'd18: return a & i;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // External ALU: garbage result and zero flag low on illegal codes.
  always_comb begin
    bus.alu_result = alu_fn(bus.alu_op_code, bus.alu_operand_a, bus.alu_operand_b,
                            bus.alu_immediate);
    bus.alu_zero   = (int'(bus.alu_op_code) <= OPMAX) &&
                     (alu_fn(bus.alu_op_code, bus.alu_operand_a, bus.alu_operand_b,
                             bus.alu_immediate) == 32'd0);
  end

  function automatic int ref_winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      bus.req_op[i*5 +: 5]    = r_op[i];
      bus.req_a[i*32 +: 32]   = r_a[i];
      bus.req_b[i*32 +: 32]   = r_b[i];
      bus.req_imm[i*12 +: 12] = r_imm[i];
    end
  endtask

  task automatic scramble_all();
    for (int i = 0; i < N; i++) begin
      r_op[i]  = 5'($urandom_range(0, 22));
      r_a[i]   = $urandom;
      r_b[i]   = $urandom;
      r_imm[i] = 12'($urandom);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_ptr = 0;
  endtask

  // Called one time unit after a rising edge in IDLE with req_valid already set.
  task automatic run_txn(input string name, input bit scr, input int hold,
                         output logic [N-1:0] grant);
    int w;
    logic [N-1:0] oh;
    logic [4:0] eop;
    logic [31:0] ea, eb, er;
    logic [11:0] eimm;
    logic ez, ei;
    pack(); #1;
    w = ref_winner(bus.req_valid);
    oh = (w < 0) ? '0 : N'(1 << w);
    grant = bus.req_ready;
    n_checks++;
    if (bus.req_ready !== oh || bus.busy !== 1'b0)
      $display("FAIL %s grant: got ready=%b busy=%b want ready=%b busy=0", name,
               bus.req_ready, bus.busy, oh);
    else n_pass++;
    if (w < 0) return;
    eop = r_op[w]; ea = r_a[w]; eb = r_b[w]; eimm = r_imm[w];
    ei = int'(eop) > OPMAX;
    er = ei ? 32'd0 : alu_fn(eop, ea, eb, eimm);
    ez = ei | (er == 32'd0);
    ref_ptr = (w + 1) % N;
    @(posedge clk); #1;
    if (scr) begin scramble_all(); pack(); end
    #1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.req_ready !== '0 || bus.rsp_valid !== '0)
      $display("FAIL %s exec: got busy=%b ready=%b rsp_valid=%b want 1/0/0", name,
               bus.busy, bus.req_ready, bus.rsp_valid);
    else n_pass++;
    n_checks++;
    if ({bus.alu_op_code, bus.alu_operand_a, bus.alu_operand_b, bus.alu_immediate} !==
        {eop, ea, eb, eimm})
      $display("FAIL %s alu_drive: got %h %h %h %h want %h %h %h %h", name,
               bus.alu_op_code, bus.alu_operand_a, bus.alu_operand_b, bus.alu_immediate,
               eop, ea, eb, eimm);
    else n_pass++;
    @(posedge clk); #1;
    for (int c = 0; c <= hold; c++) begin
      // Non-owner ready bits are randomised to show they are ignored.
      bus.rsp_ready = (c < hold) ? (N'($urandom) & ~oh) : (N'($urandom) | oh);
      n_checks++;
      if (bus.rsp_valid !== oh || bus.rsp_result !== er || bus.rsp_zero !== ez ||
          bus.rsp_illegal !== ei || bus.req_ready !== '0 || bus.busy !== 1'b1)
        $display("FAIL %s resp[%0d]: got v=%b r=%h z=%b ill=%b rdy=%b want v=%b r=%h z=%b ill=%b rdy=0",
                 name, c, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal,
                 bus.req_ready, oh, er, ez, ei);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.rsp_ready = '0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== '0)
      $display("FAIL %s back_to_idle: got busy=%b rsp_valid=%b want 0/0", name, bus.busy,
               bus.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scramble_all(); pack();
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    #2;
    n_checks++;
    if ({bus.busy, bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_zero,
         bus.rsp_illegal, bus.alu_op_code, bus.alu_operand_a, bus.alu_operand_b,
         bus.alu_immediate} !== '0)
      $display("FAIL reset: got busy=%b ready=%b v=%b r=%h z=%b ill=%b op=%h want all 0",
               bus.busy, bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_zero,
               bus.rsp_illegal, bus.alu_op_code);
    else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    rst = 1'b0;
    ref_ptr = 0;
  endtask

  task automatic test_basic_add();
    logic [N-1:0] g;
    r_op[0] = 5'd0; r_a[0] = 32'd5; r_b[0] = 32'd7; r_imm[0] = 12'd0;
    bus.req_valid = 3'b001;
    run_txn("add", 1'b0, 0, g);
    bus.req_valid = '0;
  endtask

  task automatic test_alternate();
    logic [N-1:0] g;
    apply_reset();
    r_op[0] = 5'd0; r_a[0] = 32'd10; r_b[0] = 32'd20; r_imm[0] = 12'd0;
    r_op[1] = 5'd1; r_a[1] = 32'd3;  r_b[1] = 32'd3;  r_imm[1] = 12'd0;
    bus.req_valid = 3'b011;
    for (int t = 0; t < 4; t++) begin
      run_txn("alternate", 1'b0, 0, g);
      n_checks++;
      if (g !== N'(1 << (t % 2)))
        $display("FAIL alternate_order[%0d]: got %b want %b", t, g, N'(1 << (t % 2)));
      else n_pass++;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_immediates();
    logic [N-1:0] g;
    r_op[2] = 5'd10; r_a[2] = 32'd1; r_b[2] = 32'd99; r_imm[2] = 12'hFFF;
    bus.req_valid = 3'b100;
    run_txn("addi", 1'b0, 0, g);
    r_op[2] = 5'd16; r_a[2] = 32'h8000_0000; r_imm[2] = 12'd4;
    run_txn("srai", 1'b0, 1, g);
    bus.req_valid = '0;
  endtask

  task automatic test_illegal();
    logic [N-1:0] g;
    r_op[1] = 5'd25; r_a[1] = 32'd0; r_b[1] = 32'd0; r_imm[1] = 12'd0;
    bus.req_valid = 3'b010;
    run_txn("illegal", 1'b0, 0, g);
    r_op[1] = 5'd9; r_a[1] = 32'hF0F0_1234; r_b[1] = 32'hFF00_FF00;
    run_txn("after_illegal", 1'b0, 0, g);
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g;
    r_op[0] = 5'd8; r_a[0] = 32'h1200_0000; r_b[0] = 32'h0000_0034;
    bus.req_valid = 3'b111;
    run_txn("backpressure", 1'b0, 5, g);
    bus.req_valid = '0;
  endtask

  task automatic test_drop();
    logic [N-1:0] exp;
    exp = N'(1 << ref_winner(3'b010));
    bus.req_valid = 3'b010;
    pack(); #1;
    n_checks++;
    if (bus.req_ready !== exp)
      $display("FAIL drop_ready: got %b want %b", bus.req_ready, exp);
    else n_pass++;
    bus.req_valid = '0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL drop_no_accept: got busy=%b want 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset_in_exec();
    logic [N-1:0] g;
    bus.req_valid = 3'b010;
    pack(); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== '0 || bus.alu_op_code !== 5'd0)
      $display("FAIL reset_in_exec: got busy=%b rsp_valid=%b op=%h want 0/0/0", bus.busy,
               bus.rsp_valid, bus.alu_op_code);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_ptr = 0;
    bus.req_valid = 3'b111;
    run_txn("after_reset", 1'b0, 0, g);
    n_checks++;
    if (g !== 3'b001) $display("FAIL after_reset_grant: got %b want 001", g);
    else n_pass++;
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    for (int t = 0; t < 25; t++) begin
      scramble_all();
      bus.req_valid = N'($urandom_range(1, (1 << N) - 1));
      run_txn("random", 1'b1, int'($urandom_range(0, 3)), g);
    end
    bus.req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; r_imm[i] = '0;
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    pack();
    ref_ptr = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic_add();
    test_alternate();
    test_immediates();
    test_illegal();
    test_backpressure();
    test_drop();
    test_random();
    test_reset_in_exec();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
